regfile_scoreboard: RTL and testbench

Tracks in-flight writes to the 32-entry integer register file of the pipelined core, and gates instruction issue on read-after-write hazards.
- Sits beside decode. Decode presents an instruction's source and destination indices; the block grants or stalls issue.
- Writeback retires pending destinations.
- The register file's read data is registered, so a source is clean only once its pending count has reached zero before the read edge. There is no same-cycle bypass.

---
 rtl/rf_pkg.sv | 19 +
 rtl/sb_pend_cnt.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file constants and index/count types.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     pend_cnt_t;

endpackage

`default_nettype wire

// File: rtl/sb_pend_cnt.sv
// ============================================================================
// Module      : sb_pend_cnt
// Description : Saturating up/down pending-write counter with underflow pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sb_pend_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // A simultaneous inc cancels the dec, so a zero count is not an underflow then.
  assign underflow = dec & ~inc & ~clr & w_zero;
  assign cnt       = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !dec && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Tracks in-flight register writes and stalls issue on RAW hazards.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int CNT_W = rf_pkg::CNT_W,
  parameter int NREG  = rf_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rs1_s,
  input  logic [4:0]      issue_rs2_s,
  input  logic [4:0]      issue_rd_s,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_wr_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_s,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic [5:0]      inflight,
  output logic            wb_underflow
);

  import rf_pkg::*;

  localparam reg_idx_t        C_X0     = '0;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [5:0]      C_INFL_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] w_cnt;
  logic [NREG-1:0]            w_inc_vec;
  logic [NREG-1:0]            w_dec_vec;
  logic [NREG-1:0]            w_uf_vec;
  logic                       w_raw1;
  logic                       w_raw2;
  logic                       w_sat;
  logic                       w_fire;
  logic                       w_track_inc;
  logic                       w_track_dec;
  logic [5:0]                 r_inflight;
  logic                       r_wb_underflow;

  // Hazards look at the registered counts only; a same-cycle writeback does not bypass.
  assign w_raw1 = issue_use_rs1 && (issue_rs1_s != C_X0) && (w_cnt[issue_rs1_s] != '0);
  assign w_raw2 = issue_use_rs2 && (issue_rs2_s != C_X0) && (w_cnt[issue_rs2_s] != '0);
  assign w_sat  = issue_wr_rd && (issue_rd_s != C_X0) && (w_cnt[issue_rd_s] == C_CNT_MAX);

  assign issue_ready = !(w_raw1 || w_raw2 || w_sat) && !flush;
  assign w_fire      = issue_valid && issue_ready;

  assign w_track_inc = w_fire && issue_wr_rd && (issue_rd_s != C_X0);
  assign w_track_dec = wb_valid && (wb_rd_s != C_X0) && !flush;

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (w_track_inc) begin
      w_inc_vec[issue_rd_s] = 1'b1;
    end
    if (w_track_dec) begin
      w_dec_vec[wb_rd_s] = 1'b1;
    end
  end

  assign w_cnt[0]    = '0;
  assign w_uf_vec[0] = 1'b0;
  assign busy_vec[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    sb_pend_cnt #(
      .WIDTH (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .inc       (w_inc_vec[gi]),
      .dec       (w_dec_vec[gi]),
      .cnt       (w_cnt[gi]),
      .underflow (w_uf_vec[gi])
    );
    assign busy_vec[gi] = |w_cnt[gi];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_inflight <= '0;
    end else if (w_track_inc && !w_track_dec && (r_inflight != C_INFL_MAX)) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (w_track_dec && !w_track_inc && (r_inflight != '0)) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Sticky until reset; flush deliberately leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_underflow <= 1'b0;
    end else if (|w_uf_vec) begin
      r_wb_underflow <= 1'b1;
    end
  end

  assign inflight     = r_inflight;
  assign wb_underflow = r_wb_underflow;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench for regfile_scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1_s;
  logic [4:0]  issue_rs2_s;
  logic [4:0]  issue_rd_s;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        issue_wr_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd_s;
  logic        flush;
  logic [31:0] busy_vec;
  logic [5:0]  inflight;
  logic        wb_underflow;

  int tests = 0;
  int fails = 0;

  regfile_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1_s   (issue_rs1_s),
    .issue_rs2_s   (issue_rs2_s),
    .issue_rd_s    (issue_rd_s),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_wr_rd   (issue_wr_rd),
    .wb_valid      (wb_valid),
    .wb_rd_s       (wb_rd_s),
    .flush         (flush),
    .busy_vec      (busy_vec),
    .inflight      (inflight),
    .wb_underflow  (wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
    issue_rs1_s = 0; issue_rs2_s = 0; issue_rd_s = 0;
    wb_valid = 0; wb_rd_s = 0; flush = 0;
  endtask

  task automatic drive_issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic [4:0] rd, input logic wr);
    issue_valid = 1; issue_rs1_s = rs1; issue_use_rs1 = u1;
    issue_rs2_s = rs2; issue_use_rs2 = u2; issue_rd_s = rd; issue_wr_rd = wr;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
    tests++; if (inflight !== 6'd0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    tests++; if (wb_underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got=%b exp=0", wb_underflow); end
    drive_issue(5'd3, 1, 5'd4, 1, 5'd5, 0); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    idle();
  endtask

  task automatic test_basic_issue();
    drive_issue(5'd3, 1, 5'd4, 1, 5'd5, 1); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got=%b exp=1", issue_ready); end
    tick(); idle();
    tests++; if (busy_vec !== 32'h0000_0020) begin fails++; $display("FAIL basic_busy got=%h exp=%h", busy_vec, 32'h20); end
    tests++; if (inflight !== 6'd1) begin fails++; $display("FAIL basic_inflight got=%0d exp=1", inflight); end
  endtask

  task automatic test_raw_hazard();
    drive_issue(5'd5, 1, 5'd0, 0, 5'd0, 0); #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw1_ready got=%b exp=0", issue_ready); end
    wb_valid = 1; wb_rd_s = 5'd5; #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw_wb_same_cycle got=%b exp=0", issue_ready); end
    tick(); wb_valid = 0; #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw_after_wb got=%b exp=1", issue_ready); end
    tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL raw_busy got=%h exp=%h", busy_vec, 32'h0); end
    tests++; if (inflight !== 6'd0) begin fails++; $display("FAIL raw_inflight got=%0d exp=0", inflight); end
    idle();
    drive_issue(5'd1, 0, 5'd5, 1, 5'd0, 0); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL raw2_clean got=%b exp=1", issue_ready); end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive_issue(5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL sat_fill%0d got=%b exp=1", i, issue_ready); end
      tick();
    end
    #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL sat_block got=%b exp=0", issue_ready); end
    tests++; if (inflight !== 6'd3) begin fails++; $display("FAIL sat_inflight got=%0d exp=3", inflight); end
    wb_valid = 1; wb_rd_s = 5'd7; #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL sat_wb_same got=%b exp=0", issue_ready); end
    tick(); wb_valid = 0; #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL sat_release got=%b exp=1", issue_ready); end
    tests++; if (inflight !== 6'd2) begin fails++; $display("FAIL sat_after_wb got=%0d exp=2", inflight); end
    tick(); idle();
    tests++; if (inflight !== 6'd3) begin fails++; $display("FAIL sat_refire got=%0d exp=3", inflight); end
    tests++; if (busy_vec !== 32'h0000_0080) begin fails++; $display("FAIL sat_busy got=%h exp=%h", busy_vec, 32'h80); end
    wb_valid = 1; wb_rd_s = 5'd7;
    tick(); tick(); tick();
    wb_valid = 0; #1;
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0 || wb_underflow !== 1'b0) begin
      fails++; $display("FAIL sat_drain busy=%h inflight=%0d uf=%b exp=0/0/0", busy_vec, inflight, wb_underflow);
    end
  endtask

  task automatic test_same_cycle();
    drive_issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    tick();
    wb_valid = 1; wb_rd_s = 5'd9; #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL same_ready got=%b exp=1", issue_ready); end
    tick(); idle();
    tests++; if (busy_vec !== 32'h0000_0200 || inflight !== 6'd1 || wb_underflow !== 1'b0) begin
      fails++; $display("FAIL same_cnt1 busy=%h inflight=%0d uf=%b exp=00000200/1/0", busy_vec, inflight, wb_underflow);
    end
    wb_valid = 1; wb_rd_s = 5'd9;
    tick(); wb_valid = 0;
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0 || wb_underflow !== 1'b0) begin
      fails++; $display("FAIL same_single_wb busy=%h inflight=%0d uf=%b exp=0/0/0", busy_vec, inflight, wb_underflow);
    end
    drive_issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    wb_valid = 1; wb_rd_s = 5'd9;
    tick(); idle();
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0 || wb_underflow !== 1'b0) begin
      fails++; $display("FAIL same_cnt0 busy=%h inflight=%0d uf=%b exp=0/0/0", busy_vec, inflight, wb_underflow);
    end
  endtask

  task automatic test_underflow();
    wb_valid = 1; wb_rd_s = 5'd0;
    tick(); wb_valid = 0;
    tests++; if (wb_underflow !== 1'b0) begin fails++; $display("FAIL wb_x0_ignored got=%b exp=0", wb_underflow); end
    wb_valid = 1; wb_rd_s = 5'd12;
    tick(); wb_valid = 0;
    tests++; if (wb_underflow !== 1'b1) begin fails++; $display("FAIL uf_set got=%b exp=1", wb_underflow); end
    tests++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL uf_busy got=%h exp=%h", busy_vec, 32'h0); end
    tick();
    tests++; if (wb_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got=%b exp=1", wb_underflow); end
    flush = 1; #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
    tick(); flush = 0;
    tests++; if (wb_underflow !== 1'b1) begin fails++; $display("FAIL uf_after_flush got=%b exp=1", wb_underflow); end
    rst = 1; tick(); rst = 0;
    tests++; if (wb_underflow !== 1'b0) begin fails++; $display("FAIL uf_after_rst got=%b exp=0", wb_underflow); end
  endtask

  task automatic test_x0_and_flush();
    drive_issue(5'd0, 1, 5'd0, 0, 5'd0, 1); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", issue_ready); end
    tick(); idle();
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0) begin
      fails++; $display("FAIL x0_untracked busy=%h inflight=%0d exp=0/0", busy_vec, inflight);
    end
    for (int r = 8; r < 12; r++) begin
      drive_issue(5'd0, 0, 5'd0, 0, 5'(r), 1);
      tick();
    end
    idle();
    tests++; if (busy_vec !== 32'h0000_0F00 || inflight !== 6'd4) begin
      fails++; $display("FAIL flush_pre busy=%h inflight=%0d exp=00000f00/4", busy_vec, inflight);
    end
    flush = 1; wb_valid = 1; wb_rd_s = 5'd8;
    drive_issue(5'd0, 0, 5'd0, 0, 5'd13, 1);
    tick(); idle();
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0 || wb_underflow !== 1'b0) begin
      fails++; $display("FAIL flush_clear busy=%h inflight=%0d uf=%b exp=0/0/0", busy_vec, inflight, wb_underflow);
    end
    drive_issue(5'd8, 1, 5'd11, 1, 5'd0, 0); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL flush_ready_after got=%b exp=1", issue_ready); end
    idle();
  endtask

  task automatic test_reset_midop();
    drive_issue(5'd0, 0, 5'd0, 0, 5'd13, 1);
    tick(); tick();
    rst = 1;
    tick(); rst = 0; idle();
    tests++; if (busy_vec !== 32'h0 || inflight !== 6'd0) begin
      fails++; $display("FAIL rst_midop busy=%h inflight=%0d exp=0/0", busy_vec, inflight);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_basic_issue();
    test_raw_hazard();
    test_saturation();
    test_same_cycle();
    test_underflow();
    test_x0_and_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
